dma_wr_arbiter: RTL and testbench
=================================

# dma_wr_arbiter

Round-robin arbiter that shares one core-slot DMA write command port (`dma_cmd_wr_*`, 128-bit data with header-write sideband) between `PORT_COUNT` requesters, such as the packet-data mover and the header/descriptor writer. It sits in front of the pipe register stage of a core slot. A grant is locked for a whole burst, from the first beat to the beat with `last`, so beats from different requesters never interleave. The output is a single registered stage with ready pass-through.

## Interface
- `PORT_COUNT`, 4: number of requesters (≥1)
- `DATA_WIDTH`, 128: write data width
- `STRB_WIDTH`, `DATA_WIDTH/8`: byte strobe width
- `ADDR_WIDTH`, 26: write address width
- `HDR_ADDR_WIDTH`, 24: header write address width
- `MAX_BURST`, 256: beats per burst before overrun is flagged
- `clk` in 1: clock; single clock domain
- `rst_n` in 1: reset, asynchronous assert, active-low
- `s_wr_en` in `PORT_COUNT`: per-port beat valid
- `s_wr_addr` in `PORT_COUNT*ADDR_WIDTH`: packed, port i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`
- `s_hdr_wr_en` in `PORT_COUNT`: per-port header-write flag
- `s_hdr_wr_addr` in `PORT_COUNT*HDR_ADDR_WIDTH`: packed header address
- `s_wr_data` in `PORT_COUNT*DATA_WIDTH`: packed data
- `s_wr_strb` in `PORT_COUNT*STRB_WIDTH`: packed strobes
- `s_wr_last` in `PORT_COUNT`: last beat of burst
- `s_wr_ready` out `PORT_COUNT`: per-port beat accept
- `dma_cmd_wr_en` out 1: output beat valid
- `dma_cmd_wr_addr`, `dma_cmd_hdr_wr_en`, `dma_cmd_hdr_wr_addr`, `dma_cmd_wr_data`, `dma_cmd_wr_strb`, `dma_cmd_wr_last` out (widths as above): registered beat fields
- `dma_cmd_wr_ready` in 1: downstream accept
- `grant` out `PORT_COUNT`: one-hot current owner; 0 when idle
- `busy` out 1: state is BURST
- `burst_overrun` out 1: sticky error flag

## Operation
- States:
  - IDLE: no owner, all `s_wr_ready`=0.
  - BURST: `grant` holds exactly one bit.
- In IDLE, when any `s_wr_en` is set, select the first requesting port searching upward from `rr_ptr`, wrapping at `PORT_COUNT-1`→0.
  - Next cycle: `grant` is the selected one-hot, state moves to BURST, beat counter clears to 0.
  - No request: stay in IDLE.
- Output register is free when `!dma_cmd_wr_en || dma_cmd_wr_ready`.
- In BURST, `s_wr_ready[g]` = free; all other ready bits are 0.
- Beat accepted when `s_wr_en[g] && s_wr_ready[g]`:
  - all fields of port g load into the output register;
  - `dma_cmd_wr_en` is set;
  - beat counter increments, saturating at `MAX_BURST`.
- Output register clears `dma_cmd_wr_en` when `dma_cmd_wr_ready` is high and no new beat loads in the same cycle. Field registers hold their value.
- Accepted beat with `s_wr_last[g]`=1:
  - next state is IDLE, `grant` goes to 0;
  - `rr_ptr` ← (g+1) mod `PORT_COUNT`.
- A granted port dropping `s_wr_en` mid-burst keeps the grant; bubbles are allowed.
- A non-granted port's inputs are ignored entirely.
- When the counter reaches `MAX_BURST` with no last accepted, `burst_overrun` sets and stays set until reset. The grant is still held and the burst completes normally.
- Only the header flag passes through. Header and data beats share the same burst/lock rules.
- `PORT_COUNT`=1: behaves as an IDLE/BURST pass-through with the same timing.

## Timing
- Reset values:
  - all `dma_cmd_*` outputs 0;
  - `s_wr_ready` 0, `grant` 0, `busy` 0, `burst_overrun` 0;
  - `rr_ptr` 0, beat counter 0, state IDLE.
- Reset mid-burst: everything clears asynchronously and `dma_cmd_wr_en` drops immediately. The partial burst is abandoned; downstream is reset by the same `rst_n`.
- Latency: request seen in IDLE at cycle 0 → `grant` and ready at cycle 1 → `dma_cmd_wr_en` at cycle 2 (ready downstream).
- Throughput: 1 beat/cycle within a burst when downstream holds ready.
- One mandatory IDLE cycle between bursts. Minimum 2-cycle gap from the last-beat accept to the next owner's first accept.
- `s_wr_ready` depends combinationally on `dma_cmd_wr_ready` and registered state only. There is no combinational path from `s_wr_en`.
- Downstream ready low: the output holds all fields stable and `s_wr_ready[g]`=0.
- Last beat accepted while other ports request: those requests are arbitrated in the following IDLE cycle using the updated `rr_ptr`.

## Test plan
- Single burst: port 2 sends 4 beats (data 0x..01–0x..04, last on beat 4), ready held high. Expect:
  - `dma_cmd_wr_en` cycles 2–5 with matching data/addr;
  - `grant`=0100 cycles 1–4, then 0;
  - `rr_ptr`=3.
- Round-robin fairness: all 4 ports continuously issue 2-beat bursts. Expect grant order 0,1,2,3,0, with each burst contiguous on the output and one idle cycle between bursts.
- Backpressure: `dma_cmd_wr_ready` toggles 1,0,0,1 during a 3-beat burst from port 1. Expect:
  - output fields stable while ready=0;
  - no beat lost or duplicated;
  - port 0 requesting throughout gets `s_wr_ready[0]`=0 until port 1's last beat.
- Owner bubble: granted port 3 deasserts `s_wr_en` for 5 cycles mid-burst while port 0 requests. Expect `grant` to stay 1000 until port 3's last beat.
- Overrun: `MAX_BURST`=4, port 0 sends 6 beats with last on 6. Expect:
  - `burst_overrun` set after beat 4 and still 1 after the burst;
  - all 6 beats delivered.
- Async reset: assert `rst_n`=0 mid-burst between clock edges. Expect `dma_cmd_wr_en`, `grant` and `busy` at 0 immediately. After release, the first request from port 1 is granted with `rr_ptr` starting at 0.

Source files
------------

// File: rtl/dma_wr_arbiter_if.sv
// dma_wr_arbiter_if: N-lane DMA write command bundle, per-lane fields packed side by side.
interface dma_wr_arbiter_if #(
    parameter int N = 1,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 26,
    parameter int HDR_ADDR_WIDTH = 24,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [N-1:0]                wr_en;
    logic [N*ADDR_WIDTH-1:0]     wr_addr;
    logic [N-1:0]                hdr_wr_en;
    logic [N*HDR_ADDR_WIDTH-1:0] hdr_wr_addr;
    logic [N*DATA_WIDTH-1:0]     wr_data;
    logic [N*STRB_WIDTH-1:0]     wr_strb;
    logic [N-1:0]                wr_last;
    logic [N-1:0]                wr_ready;
    modport master (
        output wr_en, wr_addr, hdr_wr_en, hdr_wr_addr, wr_data, wr_strb, wr_last,
        input  wr_ready
    );
    modport slave (
        input  wr_en, wr_addr, hdr_wr_en, hdr_wr_addr, wr_data, wr_strb, wr_last,
        output wr_ready
    );
endinterface

// File: rtl/dma_wr_arbiter.sv
// dma_wr_arbiter: round-robin arbiter sharing one DMA write command port between requesters.
// A grant is held from a burst's first beat to its last; the output is one registered stage.
module dma_wr_arbiter #(
    parameter int PORT_COUNT = 4,
    parameter int DATA_WIDTH = 128,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 26,
    parameter int HDR_ADDR_WIDTH = 24,
    parameter int MAX_BURST = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dma_wr_arbiter_if.slave       s,
    dma_wr_arbiter_if.master      m,
    output logic [PORT_COUNT-1:0] grant,
    output logic                  busy,
    output logic                  burst_overrun
);
    localparam int PW = PORT_COUNT > 1 ? $clog2(PORT_COUNT) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int BW = ADDR_WIDTH + 1 + HDR_ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH + 1;
    typedef enum logic {IDLE, BURST} state_t;
    state_t        state;
    logic [PW-1:0] rr_ptr, gidx, sel, jj;
    logic [CW-1:0] cnt;
    logic [BW-1:0] out_q;
    logic [BW-1:0] beat [PORT_COUNT];
    logic          free, take;
    for (genvar g = 0; g < PORT_COUNT; g++) begin : g_beat
        assign beat[g] = {s.wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH], s.hdr_wr_en[g],
                          s.hdr_wr_addr[g*HDR_ADDR_WIDTH +: HDR_ADDR_WIDTH],
                          s.wr_data[g*DATA_WIDTH +: DATA_WIDTH],
                          s.wr_strb[g*STRB_WIDTH +: STRB_WIDTH], s.wr_last[g]};
    end
    assign {m.wr_addr, m.hdr_wr_en, m.hdr_wr_addr, m.wr_data, m.wr_strb, m.wr_last} = out_q;
    assign busy = (state == BURST);
    assign free = !m.wr_en[0] || m.wr_ready[0];
    assign s.wr_ready = (busy && free) ? grant : '0;
    assign take = busy && free && s.wr_en[gidx];
    // descending scan so the lowest offset from rr_ptr is the one left in sel
    always_comb begin
        sel = rr_ptr;
        jj = rr_ptr;
        for (int k = PORT_COUNT - 1; k >= 0; k--) begin
            jj = PW'((int'(rr_ptr) + k) % PORT_COUNT);
            if (s.wr_en[jj]) sel = jj;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            gidx <= '0;
            rr_ptr <= '0;
            cnt <= '0;
            burst_overrun <= 1'b0;
            m.wr_en <= '0;
            out_q <= '0;
        end else begin
            if (state == IDLE) begin
                if (|s.wr_en) begin
                    state <= BURST;
                    grant <= '0;
                    grant[sel] <= 1'b1;
                    gidx <= sel;
                    cnt <= '0;
                end
            end else if (take) begin
                out_q <= beat[gidx];
                cnt <= (cnt == CW'(MAX_BURST)) ? cnt : cnt + 1'b1;
                if (beat[gidx][0]) begin
                    state <= IDLE;
                    grant <= '0;
                    rr_ptr <= (gidx == PW'(PORT_COUNT - 1)) ? '0 : gidx + 1'b1;
                end else if (cnt >= CW'(MAX_BURST - 1)) begin
                    burst_overrun <= 1'b1;
                end
            end
            m.wr_en[0] <= take ? 1'b1 : (m.wr_ready[0] ? 1'b0 : m.wr_en[0]);
        end
    end
endmodule

// File: tb/tb_dma_wr_arbiter.sv
// tb_dma_wr_arbiter: directed scoreboard bench for dma_wr_arbiter (MAX_BURST=4 to reach overrun).
module tb_dma_wr_arbiter;
    localparam int N = 4, DW = 128, SW = DW / 8, AW = 26, HW = 24, MB = 4;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic          hdr;
        logic [HW-1:0] haddr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } beat_t;
    logic clk = 0, rst_n = 0;
    logic [N-1:0] grant;
    logic busy, burst_overrun;
    beat_t drv [N];
    logic  en [N];
    beat_t sbq [$];
    beat_t held, e;
    logic [N-1:0] obs [$];
    int obs_t [$];
    logic [N-1:0] prev_grant = '0;
    int passed = 0, total = 0, cyc = 0;
    bit sb_on = 1, hold_v = 0, done3 = 0;
    dma_wr_arbiter_if #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HDR_ADDR_WIDTH(HW)) s_if ();
    dma_wr_arbiter_if #(.N(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HDR_ADDR_WIDTH(HW)) m_if ();
    dma_wr_arbiter #(.PORT_COUNT(N), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .ADDR_WIDTH(AW),
                     .HDR_ADDR_WIDTH(HW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .s(s_if), .m(m_if),
        .grant(grant), .busy(busy), .burst_overrun(burst_overrun));
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    for (genvar g = 0; g < N; g++) begin : g_drv
        assign s_if.wr_en[g] = en[g];
        assign s_if.wr_addr[g*AW +: AW] = drv[g].addr;
        assign s_if.hdr_wr_en[g] = drv[g].hdr;
        assign s_if.hdr_wr_addr[g*HW +: HW] = drv[g].haddr;
        assign s_if.wr_data[g*DW +: DW] = drv[g].data;
        assign s_if.wr_strb[g*SW +: SW] = drv[g].strb;
        assign s_if.wr_last[g] = drv[g].last;
    end
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    endtask
    task automatic fail(input string name);
        total++;
        $display("FAIL %s t=%0t", name, $time);
    endtask
    function automatic beat_t mk(input logic [1:0] p, input int id, input int b, input bit last);
        beat_t t;
        t.addr = AW'(int'(p) * 65536 + id * 256 + b);
        t.hdr = 1'((id + b) % 2);
        t.haddr = HW'(int'(p) * 4096 + id * 16 + b);
        t.data = {32'(p), 32'(id), 32'(b), 32'hC0DE0000 + 32'(b)};
        t.strb = SW'(16'hFFFF >> (b % 16));
        t.last = last;
        return t;
    endfunction
    function automatic beat_t out_beat();
        return {m_if.wr_addr, m_if.hdr_wr_en, m_if.hdr_wr_addr, m_if.wr_data, m_if.wr_strb, m_if.wr_last};
    endfunction
    // Presents nb beats on port p; the expected beat is queued at the edge that accepts it.
    task automatic send(input logic [1:0] p, input int nb, input int id,
                        input int gap_at = 0, input int gap = 0);
        for (int b = 1; b <= nb; b++) begin
            int w = 0;
            en[p] = 1;
            drv[p] = mk(p, id, b, b == nb);
            forever begin
                @(negedge clk);
                if (s_if.wr_ready[p]) break;
                if (++w > 100) begin
                    fail($sformatf("accept_timeout_p%0d", p));
                    en[p] = 0;
                    return;
                end
            end
            @(posedge clk);
            sbq.push_back(drv[p]);
            #1;
            if (b == gap_at) begin
                en[p] = 0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        en[p] = 0;
    endtask
    always @(negedge clk) begin
        if (grant != 0 && prev_grant == 0) begin
            obs.push_back(grant);
            obs_t.push_back(cyc);
        end
        prev_grant = grant;
    end
    always @(negedge clk) begin
        if (rst_n && sb_on) begin
            if (hold_v && m_if.wr_en[0]) check("hold_stable", out_beat(), held);
            hold_v = m_if.wr_en[0] && !m_if.wr_ready[0];
            held = out_beat();
            if (m_if.wr_en[0] && m_if.wr_ready[0]) begin
                if (sbq.size() == 0) fail("unexpected_beat");
                else begin
                    e = sbq.pop_front();
                    check("beat", out_beat(), e);
                end
            end
        end else hold_v = 0;
    end
    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
    initial begin
        logic [N-1:0] exp_rr [5];
        int k;
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        m_if.wr_ready = 1;
        for (int i = 0; i < N; i++) begin
            en[i] = 0;
            drv[i] = '0;
        end
        #12;
        check("rst_wr_en", m_if.wr_en, 0);
        check("rst_fields", out_beat(), 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", burst_overrun, 0);
        check("rst_ready", s_if.wr_ready, 0);
        @(negedge clk) rst_n = 1;
        // round robin: all ports with 2-beat bursts, port 0 twice
        @(negedge clk); #1;
        obs.delete(); obs_t.delete();
        fork
            begin send(0, 2, 1); send(0, 2, 2); end
            send(1, 2, 3);
            send(2, 2, 4);
            send(3, 2, 5);
        join
        repeat (3) @(negedge clk);
        check("rr_bursts", obs.size(), 5);
        for (int i = 0; i < 5 && i < obs.size(); i++) check($sformatf("rr_order%0d", i), obs[i], exp_rr[i]);
        if (obs_t.size() == 5) check("rr_spacing", obs_t[4] - obs_t[0], 12);
        else fail("rr_spacing");
        // single 4-beat burst from port 2: latency and release timing
        @(negedge clk); #1;
        fork
            send(2, 4, 6);
            begin
                @(negedge clk);
                check("sb_grant_c1", grant, 4'b0100);
                check("sb_ready_c1", s_if.wr_ready, 4'b0100);
                check("sb_en_c1", m_if.wr_en, 0);
                @(negedge clk);
                check("sb_en_c2", m_if.wr_en, 1);
                repeat (3) @(negedge clk);
                check("sb_grant_c5", grant, 0);
                check("sb_en_c5", m_if.wr_en, 1);
                @(negedge clk);
                check("sb_en_c6", m_if.wr_en, 0);
            end
        join
        check("sb_rr_ptr", dut.rr_ptr, 3);
        check("sb_no_overrun", burst_overrun, 0);
        // backpressure on a 3-beat burst from port 1 while port 0 waits
        @(negedge clk); #1;
        obs.delete();
        fork
            send(1, 3, 7);
            begin @(posedge clk); #1; send(0, 1, 8); end
            begin
                @(posedge clk); #1 m_if.wr_ready = 1;
                @(posedge clk); #1 m_if.wr_ready = 0;
                @(posedge clk); #1 m_if.wr_ready = 0;
                @(posedge clk); #1 m_if.wr_ready = 1;
            end
            repeat (10) begin
                @(negedge clk);
                if (grant[1]) check("bp_block_p0", s_if.wr_ready[0], 0);
            end
        join
        repeat (3) @(negedge clk);
        check("bp_bursts", obs.size(), 2);
        if (obs.size() == 2) check("bp_order", {obs[0], obs[1]}, {4'b0010, 4'b0001});
        // owner bubble: port 3 idles 5 cycles mid-burst, port 0 must wait
        @(negedge clk); #1;
        obs.delete();
        done3 = 0;
        fork
            begin send(3, 3, 9, 1, 5); done3 = 1; end
            begin @(posedge clk); #1; send(0, 1, 10); end
            while (!done3) begin
                @(negedge clk);
                if (!done3 && grant != 0) check("bubble_grant", grant, 4'b1000);
            end
        join
        repeat (3) @(negedge clk);
        check("bubble_bursts", obs.size(), 2);
        if (obs.size() == 2) check("bubble_order", {obs[0], obs[1]}, {4'b1000, 4'b0001});
        // overrun: 6 beats against MAX_BURST=4
        check("ov_before", burst_overrun, 0);
        @(negedge clk); #1;
        k = 0;
        fork
            send(0, 6, 11);
            repeat (12) begin
                @(negedge clk);
                if (m_if.wr_en[0] && m_if.wr_ready[0]) begin
                    k++;
                    if (k == 3) check("ov_beat3", burst_overrun, 0);
                    if (k == 4) check("ov_beat4", burst_overrun, 1);
                end
            end
        join
        repeat (2) @(negedge clk);
        check("ov_sticky", burst_overrun, 1);
        check("ov_beats", k, 6);
        check("sb_drained", sbq.size(), 0);
        // asynchronous reset in the middle of a burst
        sb_on = 0;
        @(negedge clk); #1;
        en[2] = 1;
        drv[2] = mk(2, 12, 1, 0);
        repeat (3) @(negedge clk);
        check("ar_busy_pre", busy, 1);
        check("ar_en_pre", m_if.wr_en, 1);
        @(posedge clk); #2 rst_n = 0;
        #1;
        check("ar_en", m_if.wr_en, 0);
        check("ar_grant", grant, 0);
        check("ar_busy", busy, 0);
        check("ar_overrun", burst_overrun, 0);
        check("ar_ready", s_if.wr_ready, 0);
        en[2] = 0;
        sbq.delete();
        @(negedge clk) rst_n = 1;
        sb_on = 1;
        check("ar_rr_ptr", dut.rr_ptr, 0);
        @(negedge clk); #1;
        obs.delete();
        fork
            send(1, 1, 13);
            send(3, 1, 14);
        join
        repeat (3) @(negedge clk);
        check("ar_bursts", obs.size(), 2);
        if (obs.size() == 2) check("ar_order", {obs[0], obs[1]}, {4'b0010, 4'b1000});
        check("final_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
